mem_dump_unit: RTL and testbench

- Debug-path consumer of the data memory: on request, walks data-memory words 0..MEM_DEPTH-1 through the memory's debug read port.
- Asserts the memory's debug-enable while the walk runs, captures each returned word and serialises it as 4 bytes to the UART transmitter using a start/done handshake.
- Sits between the data memory's debug port and the debug UART TX.

---
 rtl/mem_dump_pkg.sv | 32 +++
 rtl/mem_dump_unit_word_byte_serializer.sv | 45 ++++
 rtl/mem_dump_unit.sv | 125 ++++++++++++
 tb/tb_mem_dump_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared debug-dump definitions: FSM encoding and byte order.
// Used by the memory and register-file dump blocks.
package mem_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_DONE    = 3'd5
    } dump_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    // Debug byte order is MSB first: index 0 is bits [31:24].
    function automatic logic [7:0] dbg_byte_sel(
        input logic [31:0]           word,
        input logic [BYTE_IDX_W-1:0] idx
    );
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_dump_unit_word_byte_serializer.sv
// Captures one 32-bit word and presents it one byte at a time.
// Shared with the register-file dumper.
module word_byte_serializer
    import mem_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_next,
    output logic [7:0]  o_byte,
    output logic        o_last
);

    logic [31:0]           word_q, word_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX =
        BYTE_IDX_W'(BYTES_PER_WORD - 1);

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (i_load) begin
            word_d = i_word;
            idx_d  = '0;
        end else if (i_next) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign o_byte = dbg_byte_sel(word_q, idx_q);
    assign o_last = (idx_q == LAST_IDX);

endmodule

// File: rtl/mem_dump_unit.sv
// Walks data memory through its debug port and streams every
// word MSB-first to the debug UART transmitter.
module mem_dump_unit
    import mem_dump_pkg::*;
#(
    parameter int MEM_DEPTH = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_tx_done,
    output logic              o_debug_on,
    output logic [31:0]       o_mem_addr,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W =
        (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT =
        CNT_W'(MEM_DEPTH - 1);

    dump_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             debug_on_q, debug_on_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic ser_load;
    logic ser_next;
    logic ser_last;

    // Memory data registered on the ADDR-cycle negedge is
    // latched on the edge that leaves ADDR.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ser_load = 1'b0;
        ser_next = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_ADDR: begin
                state_d  = ST_CAPTURE;
                ser_load = 1'b1;
            end
            ST_CAPTURE: state_d = ST_SEND;
            ST_SEND:    state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    if (!ser_last) begin
                        ser_next = 1'b1;
                        state_d  = ST_SEND;
                    end else if (cnt_q < LAST_CNT) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        debug_on_d = (state_d == ST_ADDR)    ||
                     (state_d == ST_CAPTURE) ||
                     (state_d == ST_SEND)    ||
                     (state_d == ST_WAIT_TX);
        mem_addr_d = (state_d == ST_IDLE) ? 32'd0
                                          : 32'(cnt_d);
        tx_start_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            debug_on_q <= 1'b0;
            mem_addr_q <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            debug_on_q <= debug_on_d;
            mem_addr_q <= mem_addr_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    word_byte_serializer u_ser (
        .clk    (clk),
        .rst    (rst),
        .i_load (ser_load),
        .i_word (i_mem_data[31:0]),
        .i_next (ser_next),
        .o_byte (o_tx_data),
        .o_last (ser_last)
    );

    assign o_debug_on = debug_on_q;
    assign o_mem_addr = mem_addr_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit: 32-word and 1-word builds.
module tb_mem_dump_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // ---------------- DUT a: 32 words ----------------
    logic        a_start = 1'b0;
    logic [31:0] a_mem_data = '0;
    logic        a_tx_done;
    logic        a_debug_on, a_tx_start, a_busy, a_done;
    logic [31:0] a_mem_addr;
    logic [7:0]  a_tx_data;

    mem_dump_unit #(.MEM_DEPTH(32), .DATA_W(32)) dut_a (
        .clk(clk), .rst(rst), .i_start(a_start),
        .i_mem_data(a_mem_data), .i_tx_done(a_tx_done),
        .o_debug_on(a_debug_on), .o_mem_addr(a_mem_addr),
        .o_tx_data(a_tx_data), .o_tx_start(a_tx_start),
        .o_busy(a_busy), .o_done(a_done)
    );

    logic [31:0] mem [32];
    always @(negedge clk)
        if (a_debug_on) a_mem_data = mem[a_mem_addr[4:0]];

    logic auto_en = 1'b1;
    logic auto_done = 1'b0;
    logic man_done = 1'b0;
    int   a_cnt = 0;
    assign a_tx_done = auto_done | man_done;

    always @(negedge clk) begin
        if (rst) begin
            a_cnt = 0;
            auto_done = 1'b0;
        end else begin
            auto_done = 1'b0;
            if (auto_en && a_tx_start) a_cnt = 10;
            else if (a_cnt > 0) begin
                a_cnt--;
                if (a_cnt == 0) auto_done = 1'b1;
            end
        end
    end

    logic [7:0]  aq[$];
    int          a_dn = 0;
    logic        lat_en = 1'b0;
    logic [31:0] h1_addr = '0, h2_addr = '0;
    logic        h1_dbg = 1'b0, h2_dbg = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_tx_start) begin
                if (lat_en && (aq.size() % 4 == 0)) begin
                    int k;
                    k = aq.size() / 4;
                    if (k == 0 || k == 15 || k == 31) begin
                        chk($sformatf("addr_w%0d", k), h2_addr, k);
                        chk($sformatf("dbg_w%0d", k), h2_dbg, 1);
                        chk($sformatf("addr_hold_w%0d", k),
                            h1_addr, k);
                    end
                end
                aq.push_back(a_tx_data);
            end
            if (a_done) a_dn++;
        end
        h2_addr = h1_addr;
        h2_dbg  = h1_dbg;
        h1_addr = a_mem_addr;
        h1_dbg  = a_debug_on;
    end

    function automatic logic [31:0] aw(input int w);
        if (aq.size() < 4 * w + 4) return 32'hFFFF_FFFF;
        return {aq[4*w], aq[4*w+1], aq[4*w+2], aq[4*w+3]};
    endfunction

    // ---------------- DUT b: 1 word ----------------
    logic        b_start = 1'b0;
    logic [31:0] b_mem_data = '0;
    logic        b_tx_done = 1'b0;
    logic        b_debug_on, b_tx_start, b_busy, b_done;
    logic [31:0] b_mem_addr;
    logic [7:0]  b_tx_data;
    int          b_cnt = 0;
    int          b_dn = 0;
    logic [7:0]  bq[$];

    mem_dump_unit #(.MEM_DEPTH(1), .DATA_W(32)) dut_b (
        .clk(clk), .rst(rst), .i_start(b_start),
        .i_mem_data(b_mem_data), .i_tx_done(b_tx_done),
        .o_debug_on(b_debug_on), .o_mem_addr(b_mem_addr),
        .o_tx_data(b_tx_data), .o_tx_start(b_tx_start),
        .o_busy(b_busy), .o_done(b_done)
    );

    always @(negedge clk) begin
        if (b_debug_on)
            b_mem_data = (b_mem_addr == 0) ? 32'hDEADBEEF : '0;
        b_tx_done = 1'b0;
        if (!rst) begin
            if (b_tx_start) begin
                bq.push_back(b_tx_data);
                b_cnt = 3;
            end else if (b_cnt > 0) begin
                b_cnt--;
                if (b_cnt == 0) b_tx_done = 1'b1;
            end
            if (b_done) b_dn++;
        end
    end

    task automatic pulse_a_start();
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
    endtask

    task automatic wait_a_done(input int budget);
        int n;
        n = 0;
        while (a_dn == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        logic seen;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0A0B0C0D + i;

        #1;
        chk("rst_debug_on", a_debug_on, 0);
        chk("rst_addr", a_mem_addr, 0);
        chk("rst_tx_start", a_tx_start, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_tx_data", a_tx_data, 0);
        chk("rst_done", a_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full dump with extra i_start pulses mid-dump.
        lat_en = 1'b1;
        pulse_a_start();
        n = 0;
        while (a_dn == 0 && n < 4000) begin
            @(negedge clk);
            a_start = (aq.size() == 5 || aq.size() == 60);
            n++;
        end
        a_start = 1'b0;
        lat_en = 1'b0;
        chk("t1_done_seen", a_dn > 0, 1);
        repeat (3) @(negedge clk);
        chk("t1_bytes", aq.size(), 128);
        chk("t1_first", aw(0), 32'h0A0B0C0D);
        chk("t1_w15", aw(15), 32'h0A0B0C1C);
        chk("t1_last", aw(31), 32'h0A0B0C2C);
        chk("t1_done_cnt", a_dn, 1);
        chk("t1_busy_after", a_busy, 0);
        chk("t1_addr_idle", a_mem_addr, 0);
        chk("t1_dbg_idle", a_debug_on, 0);

        // tx_done coincident with tx_start is ignored.
        aq.delete();
        a_dn = 0;
        auto_en = 1'b0;
        pulse_a_start();
        n = 0;
        while (!a_tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t2_first_start", a_tx_start, 1);
        man_done = 1'b1;
        @(negedge clk) man_done = 1'b0;
        chk("t2_no_start", a_tx_start, 0);
        chk("t2_busy", a_busy, 1);
        repeat (6) @(negedge clk);
        chk("t2_held_bytes", aq.size(), 1);
        chk("t2_data_held", a_tx_data, 8'h0A);
        auto_en = 1'b1;
        man_done = 1'b1;
        @(negedge clk) man_done = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 5) begin
            if (a_tx_start) seen = 1'b1;
            else @(negedge clk);
            n++;
        end
        chk("t2_second_start", seen, 1);
        chk("t2_second_byte", a_tx_data, 8'h0B);

        // Async reset during word 7 WAIT_TX.
        n = 0;
        while (aq.size() < 29 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("t3_reached_w7", aq.size(), 29);
        #3 rst = 1'b1;
        #1;
        chk("t3_debug_on", a_debug_on, 0);
        chk("t3_addr", a_mem_addr, 0);
        chk("t3_tx_start", a_tx_start, 0);
        chk("t3_busy", a_busy, 0);
        chk("t3_tx_data", a_tx_data, 0);
        chk("t3_done", a_done, 0);
        @(negedge clk) rst = 1'b0;
        chk("t3_no_done", a_dn, 0);
        aq.delete();
        pulse_a_start();
        wait_a_done(4000);
        chk("t3_done_seen", a_dn, 1);
        chk("t3_bytes", aq.size(), 128);
        chk("t3_first", aw(0), 32'h0A0B0C0D);
        chk("t3_w7", aw(7), 32'h0A0B0C14);

        // One-word build.
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        n = 0;
        while (b_dn == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_done_seen", b_dn, 1);
        chk("t4_bytes", bq.size(), 4);
        if (bq.size() == 4)
            chk("t4_word", {bq[0], bq[1], bq[2], bq[3]},
                32'hDEADBEEF);
        @(negedge clk);
        chk("t4_busy_after", b_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
